alu_result_stage: RTL and testbench

Downstream companion of the registered 4-bit ALU. Tracks each issued operation through the ALU's two register stages, selects the result matching the issued opcode from the ALU's parallel outputs, generates status flags, and buffers results in a small FIFO with a valid/ready output handshake. A credit-based `in_ready` back-pressures the issuer so that no result is ever dropped, even though the ALU itself cannot stall.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_res_fifo.sv | 64 ++++++
 rtl/alu_result_stage.sv | 118 +++++++++++
 tb/tb_alu_result_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings, flag bit
// positions and the result-entry layout. Parity build: ALU_RES_PARITY_EN
// adds the P flag, widening the flag field from 3 to 4 bits.
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;

  localparam int FLG_Z   = 0;
  localparam int FLG_C   = 1;
  localparam int FLG_ILL = 2;
  localparam int FLG_P   = 3;

`ifdef ALU_RES_PARITY_EN
  localparam int FLAG_W = 4;
`else
  localparam int FLAG_W = 3;
`endif

  localparam int ALU_W = 4;

  typedef logic [FLAG_W-1:0] flags_t;

  // One queued result at the native ALU width.
  typedef struct packed {
    flags_t             flags;
    logic [ALU_W-1:0]   result;
  } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Result FIFO: circular buffer with read/write pointers and occupancy count.
// Latency: entry written at an edge is visible at rd_dat_o right after it.
// Backpressure: no full check on write (upstream credit guarantees room);
// pop on empty ignored.
// Ports: clk_i/rst_ni clock and async active-low reset; wr_vld_i/wr_dat_i
// write side; rd_vld_o/rd_rdy_i/rd_dat_o head handshake; count_o occupancy.
module alu_res_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_vld_i,
  input  logic [DW-1:0] wr_dat_i,
  output logic          rd_vld_o,
  input  logic          rd_rdy_i,
  output logic [DW-1:0] rd_dat_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign push = wr_vld_i;
  assign pop  = rd_rdy_i && (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // DEPTH is a power of two, so pointer increments wrap naturally.
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push) mem_q[wptr_q] <= wr_dat_i;
    end
  end

  assign rd_vld_o = (cnt_q != '0);
  assign rd_dat_o = mem_q[rptr_q];
  assign count_o  = cnt_q;

endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the 2-register ALU: tags ops, selects result, makes flags, queues them.
// Latency: 3 edges from acceptance to out_valid; one result per cycle sustained.
// Backpressure: credit-based in_ready (queued + in flight < DEPTH), registered, so no loss.
// Ports: clk/rst (async active-low); in_valid/opcode/in_ready issue side;
// out_*_reg/carry_out_reg ALU registered outputs; out_valid/out_ready/
// out_result/out_flags result handshake. Build option ALU_RES_PARITY_EN adds P flag.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        opcode,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  out_not_reg,
  input  logic [WIDTH-1:0]  out_and_reg,
  input  logic [WIDTH-1:0]  out_xor_reg,
  input  logic [WIDTH-1:0]  sum_out_reg,
  input  logic              carry_out_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // Wide enough for a full FIFO plus both in-flight tags.
  localparam int CRW   = $clog2(DEPTH + 3);

  typedef struct packed {
    flags_t             flags;
    logic [WIDTH-1:0]   result;
  } entry_t;

  logic       s1_vld_q, s1_vld_d, s2_vld_q;
  logic [2:0] s1_op_q,  s1_op_d,  s2_op_q;

  logic [CNT_W-1:0] fifo_cnt;
  logic [CRW-1:0]   credit;
  entry_t           wr_ent, rd_ent;
  logic [WIDTH-1:0] sel_res;
  logic             ill, cy;
  flags_t           flg;

  // Tag pipeline mirrors the ALU's input and output registers.
  assign s1_vld_d = in_valid & in_ready;
  assign s1_op_d  = opcode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_op_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_op_q  <= s1_op_d;
      s2_vld_q <= s1_vld_q;
      s2_op_q  <= s1_op_q;
    end
  end

  // S2's opcode lines up with the ALU outputs in the same cycle.
  always_comb begin
    sel_res = '0;
    ill     = 1'b0;
    cy      = 1'b0;
    case (s2_op_q)
      OP_NOT:  sel_res = out_not_reg;
      OP_AND:  sel_res = out_and_reg;
      OP_XOR:  sel_res = out_xor_reg;
      OP_ADD: begin
        sel_res = sum_out_reg;
        cy      = carry_out_reg;
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    flg          = '0;
    flg[FLG_Z]   = !ill && (sel_res == '0);
    flg[FLG_C]   = cy;
    flg[FLG_ILL] = ill;
`ifdef ALU_RES_PARITY_EN
    // sel_res is zero for illegal opcodes, so P is zero there as well.
    flg[FLG_P]   = ^sel_res;
`endif
  end

  assign wr_ent.flags  = flg;
  assign wr_ent.result = sel_res;

  alu_res_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst),
    .wr_vld_i (s2_vld_q),
    .wr_dat_i (wr_ent),
    .rd_vld_o (out_valid),
    .rd_rdy_i (out_ready),
    .rd_dat_o (rd_ent),
    .count_o  (fifo_cnt)
  );

  assign out_result = rd_ent.result;
  assign out_flags  = rd_ent.flags;

  // Credit uses only registered state: no out_ready -> in_ready path.
  assign credit   = CRW'(fifo_cnt) + CRW'(s1_vld_q) + CRW'(s2_vld_q);
  assign in_ready = (credit < CRW'(DEPTH));

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [W-1:0]      res;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] res;
    logic [2:0]   f3;   // {ILL, C, Z}
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [2:0]        opcode;
  logic              in_ready;
  logic [W-1:0]      out_not_reg, out_and_reg, out_xor_reg, sum_out_reg;
  logic              carry_out_reg;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_result;
  logic [FLAG_W-1:0] out_flags;

  logic [W-1:0] a_in, b_in, a_q, b_q;
  logic         c_in, c_q;

  exp_t cur_exp;
  exp_t sb[$];
  int   pop_cyc[$];
  vec_t tv[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   cyc_n = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .opcode        (opcode),
    .in_ready      (in_ready),
    .out_not_reg   (out_not_reg),
    .out_and_reg   (out_and_reg),
    .out_xor_reg   (out_xor_reg),
    .sum_out_reg   (sum_out_reg),
    .carry_out_reg (carry_out_reg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags)
  );

  // Two-register ALU: operands captured at one edge, results at the next.
  always @(posedge clk) begin
    a_q <= a_in;
    b_q <= b_in;
    c_q <= c_in;
    out_not_reg <= ~a_q;
    out_and_reg <= a_q & b_q;
    out_xor_reg <= a_q ^ b_q;
    {carry_out_reg, sum_out_reg} <= {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, c_q};
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] res, input logic [2:0] f3);
    exp_t e;
    e.res   = res;
    e.flags = '0;
    e.flags[2:0] = f3;
`ifdef ALU_RES_PARITY_EN
    e.flags[3] = ^res;
`endif
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
    logic [W:0]   s;
    logic [W-1:0] r;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    case (op)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a ^ b;
      3'd3: r = s[W-1:0];
      default: return mk('0, 3'b100);
    endcase
    return mk(r, {1'b0, (op == 3'd3) ? s[W] : 1'b0, (r == '0)});
  endfunction

  // Scoreboard: push on acceptance, pop and compare on output handshake.
  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc_n);
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("out_result_flags", 32'({out_flags, out_result}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c, input exp_t e);
    in_valid = 1'b1;
    opcode   = op;
    a_in     = a;
    b_in     = b;
    c_in     = c;
    cur_exp  = e;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 60) begin
      cyc();
      t++;
    end
    check(nm, 32'(sb.size()), 32'd0);
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] res, input logic [2:0] f3);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.res = res; v.f3 = f3;
    tv.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b0; in_valid = 1'b0; opcode = '0; a_in = '0; b_in = '0; c_in = 1'b0;
    out_ready = 1'b0; cur_exp = '0;

    add_vec(OP_NOT, 4'h9, 4'h7, 1'b0, 4'h6, 3'b000);
    add_vec(OP_AND, 4'h9, 4'h7, 1'b0, 4'h1, 3'b000);
    add_vec(OP_XOR, 4'h9, 4'h7, 1'b0, 4'hE, 3'b000);
    add_vec(OP_ADD, 4'h9, 4'h7, 1'b0, 4'h0, 3'b011);
    add_vec(3'b101, 4'h9, 4'h7, 1'b0, 4'h0, 3'b100);
    add_vec(OP_XOR, 4'h3, 4'h4, 1'b0, 4'h7, 3'b000);
    add_vec(OP_AND, 4'hF, 4'h0, 1'b0, 4'h0, 3'b001);
    add_vec(OP_NOT, 4'hF, 4'h2, 1'b0, 4'h0, 3'b001);
    add_vec(OP_ADD, 4'h3, 4'h4, 1'b1, 4'h8, 3'b000);
    add_vec(OP_ADD, 4'hF, 4'hF, 1'b1, 4'hF, 3'b010);
    add_vec(3'b111, 4'h0, 4'h0, 1'b0, 4'h0, 3'b100);
    add_vec(OP_ADD, 4'h0, 4'h0, 1'b0, 4'h0, 3'b001);
    add_vec(OP_XOR, 4'hA, 4'hA, 1'b0, 4'h0, 3'b001);

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_in_ready",   32'(in_ready),   32'd1);
    check("reset_out_result", 32'(out_result), 32'd0);
    check("reset_out_flags",  32'(out_flags),  32'd0);
    rst = 1'b1;
    cyc();

    // Table vectors, back to back, consumer always ready.
    out_ready = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].op, tv[i].a, tv[i].b, tv[i].c, mk(tv[i].res, tv[i].f3));
      cyc();
    end
    in_valid = 1'b0;
    drain("table_drain");

    // Latency: out_valid rises after the third edge from acceptance.
    drive(OP_XOR, 4'h5, 4'h6, 1'b0, mk(4'h3, 3'b000));
    cyc();
    in_valid = 1'b0;
    @(negedge clk); check("lat_after_e0", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_after_e1", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_after_e2", 32'(out_valid), 32'd1);
    #1;
    drain("lat_drain");

    // Streaming ADDs: one result per cycle, in order.
    pop_cyc.delete();
    for (int i = 1; i <= 7; i++) begin
      drive(OP_ADD, W'(i), W'(i), 1'b0, mk(W'(2 * i), 3'b000));
      cyc();
    end
    in_valid = 1'b0;
    drain("stream_drain");
    check("stream_pop_count", 32'(pop_cyc.size()), 32'd7);
    for (int k = 0; k + 1 < pop_cyc.size(); k++)
      check("stream_gap", 32'(pop_cyc[k+1] - pop_cyc[k]), 32'd1);

    // Back-pressure: consumer stalled, issuer streams.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      logic         c;
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      c  = 1'($urandom);
      drive(op, a, b, c, model(op, a, b, c));
      cyc();
    end
    in_valid = 1'b0;
    check("bp_accepted",    32'(n_acc),    32'(D));
    check("bp_in_ready",    32'(in_ready), 32'd0);
    check("bp_out_valid",   32'(out_valid), 32'd1);
    held = out_result;
    repeat (3) cyc();
    check("bp_head_stable", 32'(out_result), 32'(held));
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Reset with 1 entry queued and 2 in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(OP_NOT, W'(i), 4'h0, 1'b0, mk(~W'(i), 3'b000));
      cyc();
    end
    in_valid = 1'b0;
    check("rst_pre_queued", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_result", 32'(out_result), 32'd0);
    sb.delete();
    pop_cyc.delete();
    cyc();
    cyc();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (8) cyc();
    check("rst_nothing_emerges", 32'(pop_cyc.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
